// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the single-port memory controller: default widths,
// the controller FSM state type, the requester identifier type and a helper
// that sizes the anti-starvation counter.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_ADDR_W     = 10;
  localparam int MEM_DATA_W     = 32;
  localparam int MEM_STARVE_MAX = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } mem_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_LS
  } req_id_t;

  // Width needed to count from 0 up to max inclusive, never less than one bit.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
// Grant generation for the two requesters of mem_ctrl. Load/store normally
// wins; once it has won STARVE_MAX times in a row while a fetch was waiting,
// the fetch is granted instead.
//
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   en         : grants may be issued (controller idle and not in reset)
//   if_valid   : fetch request pending
//   ls_valid   : load/store request pending
//   grant_if   : fetch granted this cycle (doubles as if_req_ready)
//   grant_ls   : load/store granted this cycle (doubles as ls_req_ready)
// -----------------------------------------------------------------------------
module mem_arb
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = MEM_STARVE_MAX,
  localparam int CNT_W = cnt_width(STARVE_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // Decide the winner. Fetch only beats a pending load/store when the
  // load/store side has already used up its allowance of consecutive wins.
  // A requester that is not valid can never be granted, so a grant is also
  // a completed request handshake.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (en) begin
      if (if_valid && (!ls_valid || (starve_cnt == CNT_MAX))) begin
        grant_if = 1'b1;
      end else if (ls_valid) begin
        grant_ls = 1'b1;
      end
    end
  end

  // Track how many load/store grants in a row have gone by while a fetch
  // was waiting. A fetch grant, or a load/store grant with no fetch
  // waiting, starts the count over; the count stops at its ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls) begin
      if (!if_valid) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Single-port memory controller between the CORDIC core and the ram block.
// Arbitrates instruction fetch (read-only) and load/store (read/write),
// runs one transaction at a time around the RAM's one-cycle registered read
// latency, and returns read data on valid/ready response channels.
//
// Ports:
//   clk, rst                                  : clock, async active-high reset
//   if_req_valid/if_req_ready/if_req_addr     : fetch request
//   if_rsp_valid/if_rsp_ready/if_rsp_data     : fetch response
//   ls_req_valid/ls_req_ready/ls_req_we       : load/store request handshake
//   ls_req_addr/ls_req_wdata                  : load/store address, store data
//   ls_rsp_valid/ls_rsp_ready/ls_rsp_data     : load response (loads only)
//   ram_wr_en/ram_address/ram_data_in         : drive to the RAM
//   ram_data_out                              : RAM read data, one cycle late
//   busy                                      : high whenever not IDLE
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = MEM_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  mem_state_t state;
  mem_state_t next_state;
  req_id_t    owner;
  logic       grant_if;
  logic       grant_ls;
  logic       arb_en;
  logic       rsp_done;

  // Grants are only offered while idle, and never while reset is held, so
  // both readies read 0 during reset regardless of the request valids.
  assign arb_en = (state == IDLE) && !rst;

  mem_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .if_valid(if_req_valid),
    .ls_valid(ls_req_valid),
    .grant_if(grant_if),
    .grant_ls(grant_ls)
  );

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign if_rsp_valid = (state == RESP) && (owner == REQ_IF);
  assign ls_rsp_valid = (state == RESP) && (owner == REQ_LS);
  assign rsp_done     = (if_rsp_valid && if_rsp_ready) || (ls_rsp_valid && ls_rsp_ready);
  assign busy         = (state != IDLE);

  // State register for the transaction sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Walk each transaction through the RAM. During ACCESS the registered
  // write enable tells a store (done after one cycle) from a read, which
  // needs a CAPTURE cycle for the RAM's registered output before the
  // response can be offered.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (grant_if || grant_ls) next_state = ACCESS;
      ACCESS:  next_state = ram_wr_en ? IDLE : CAPTURE;
      CAPTURE: next_state = RESP;
      RESP:    if (rsp_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM drive and response registers. The granted request is captured at
  // the handshake edge so the requester is free to change its inputs
  // afterwards. The write enable is a pulse: set at the handshake of a
  // store and cleared at the end of ACCESS. Read data is copied out of the
  // RAM in CAPTURE into the owner's response register, which then holds
  // until the owner's next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr_en   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      owner       <= REQ_IF;
      if_rsp_data <= '0;
      ls_rsp_data <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      if (grant_ls) begin
        ram_address <= ls_req_addr;
        ram_data_in <= ls_req_wdata;
        ram_wr_en   <= ls_req_we;
        owner       <= REQ_LS;
      end else if (grant_if) begin
        ram_address <= if_req_addr;
        owner       <= REQ_IF;
      end
      if (state == CAPTURE) begin
        if (owner == REQ_IF) begin
          if_rsp_data <= ram_data_out;
        end else begin
          ls_rsp_data <= ram_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl with a behavioural ram attached. Expected
// grants, data and timing come from a transaction-level model of the
// controller's rules and a shadow copy of memory kept by the bench.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 2;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req_valid = 1'b0;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr = '0;
  logic              if_rsp_valid;
  logic              if_rsp_ready = 1'b0;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid = 1'b0;
  logic              ls_req_ready;
  logic              ls_req_we = 1'b0;
  logic [ADDR_W-1:0] ls_req_addr = '0;
  logic [DATA_W-1:0] ls_req_wdata = '0;
  logic              ls_rsp_valid;
  logic              ls_rsp_ready = 1'b0;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic              busy;

  logic [DATA_W-1:0] ram_mem [0:DEPTH-1];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                starve_model = 0;
  logic [DATA_W-1:0] last_if_data = '0;
  logic [DATA_W-1:0] last_ls_data = '0;
  int                cycle_cnt = 0;
  int                vectorCount = 0;
  int                missCount = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure handshake spacing.
  always @(posedge clk) cycle_cnt++;

  // Behavioural single-port RAM with a one-cycle registered read.
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_mem[ram_address];
  end

  mem_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_req_addr (if_req_addr),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_ready(if_rsp_ready),
    .if_rsp_data (if_rsp_data),
    .ls_req_valid(ls_req_valid),
    .ls_req_ready(ls_req_ready),
    .ls_req_we   (ls_req_we),
    .ls_req_addr (ls_req_addr),
    .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid),
    .ls_rsp_ready(ls_rsp_ready),
    .ls_rsp_data (ls_rsp_data),
    .ram_wr_en   (ram_wr_en),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .busy        (busy)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Every output at its reset value; request valids are low when called.
  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_wr_en"}, ram_wr_en, 0);
    checkOutput({pfx, "_ram_addr"}, ram_address, 0);
    checkOutput({pfx, "_ram_din"}, ram_data_in, 0);
    checkOutput({pfx, "_if_data"}, if_rsp_data, 0);
    checkOutput({pfx, "_ls_data"}, ls_rsp_data, 0);
    checkOutput({pfx, "_if_rsp_valid"}, if_rsp_valid, 0);
    checkOutput({pfx, "_ls_rsp_valid"}, ls_rsp_valid, 0);
    checkOutput({pfx, "_if_ready"}, if_req_ready, 0);
    checkOutput({pfx, "_ls_ready"}, ls_req_ready, 0);
  endtask

  // One request opportunity starting in an idle cycle. The model picks the
  // winner from the arbitration rule, then the transaction is followed
  // cycle by cycle against its expected timing and data. Called just after
  // a rising edge; returns just after the edge that leaves the controller
  // idle again.
  task automatic applyStimulus(input bit if_v, input logic [ADDR_W-1:0] if_a,
                               input bit ls_v, input bit ls_we,
                               input logic [ADDR_W-1:0] ls_a, input logic [DATA_W-1:0] ls_d,
                               input int rsp_wait, input bit scramble,
                               output int granted, output int accept_cycle);
    bit exp_if, exp_ls, is_store, own_if;
    logic [ADDR_W-1:0] tgt;
    logic [DATA_W-1:0] exp_data;
    if_req_valid = if_v;
    if_req_addr  = if_a;
    ls_req_valid = ls_v;
    ls_req_we    = ls_we;
    ls_req_addr  = ls_a;
    ls_req_wdata = ls_d;
    if_rsp_ready = 1'b0;
    ls_rsp_ready = 1'b0;
    exp_if = if_v && (!ls_v || starve_model == STARVE_MAX);
    exp_ls = ls_v && !exp_if;

    @(negedge clk);
    granted = if_req_ready ? 1 : (ls_req_ready ? 2 : 0);
    accept_cycle = cycle_cnt;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_wr_en", ram_wr_en, 0);
    checkOutput("if_req_ready", if_req_ready, exp_if);
    checkOutput("ls_req_ready", ls_req_ready, exp_ls);
    checkOutput("idle_if_rsp_valid", if_rsp_valid, 0);
    checkOutput("idle_ls_rsp_valid", ls_rsp_valid, 0);
    checkOutput("if_rsp_data_hold", if_rsp_data, last_if_data);
    checkOutput("ls_rsp_data_hold", ls_rsp_data, last_ls_data);

    if (exp_if) starve_model = 0;
    else if (exp_ls) starve_model = if_v ? ((starve_model < STARVE_MAX) ? starve_model + 1 : STARVE_MAX) : 0;

    @(posedge clk); #1;
    if (!exp_if && !exp_ls) return;

    own_if   = exp_if;
    is_store = exp_ls && ls_we;
    tgt      = exp_if ? if_a : ls_a;
    if (scramble) begin
      if_req_valid = 1'($urandom);
      ls_req_valid = 1'($urandom);
      if_req_addr  = ADDR_W'($urandom);
      ls_req_addr  = ADDR_W'($urandom);
      ls_req_we    = 1'($urandom);
      ls_req_wdata = $urandom;
    end

    @(negedge clk);
    checkOutput("access_busy", busy, 1);
    checkOutput("access_wr_en", ram_wr_en, is_store);
    checkOutput("access_addr", ram_address, tgt);
    checkOutput("access_if_ready", if_req_ready, 0);
    checkOutput("access_ls_ready", ls_req_ready, 0);
    if (is_store) begin
      checkOutput("access_din", ram_data_in, ls_d);
      ref_mem[tgt] = ls_d;
      @(posedge clk); #1;
      return;
    end

    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("capture_busy", busy, 1);
    checkOutput("capture_wr_en", ram_wr_en, 0);
    checkOutput("capture_addr", ram_address, tgt);
    checkOutput("capture_if_rsp_valid", if_rsp_valid, 0);
    checkOutput("capture_ls_rsp_valid", ls_rsp_valid, 0);

    @(posedge clk); #1;
    exp_data = ref_mem[tgt];
    for (int w = 0; w <= rsp_wait; w++) begin
      if (own_if) begin
        if_rsp_ready = (w == rsp_wait);
        ls_rsp_ready = 1'($urandom);
      end else begin
        ls_rsp_ready = (w == rsp_wait);
        if_rsp_ready = 1'($urandom);
      end
      @(negedge clk);
      checkOutput("resp_busy", busy, 1);
      checkOutput("resp_if_valid", if_rsp_valid, own_if);
      checkOutput("resp_ls_valid", ls_rsp_valid, !own_if);
      checkOutput("resp_if_ready", if_req_ready, 0);
      checkOutput("resp_ls_ready", ls_req_ready, 0);
      if (own_if) begin
        checkOutput("resp_if_data", if_rsp_data, exp_data);
        checkOutput("resp_ls_data_hold", ls_rsp_data, last_ls_data);
      end else begin
        checkOutput("resp_ls_data", ls_rsp_data, exp_data);
        checkOutput("resp_if_data_hold", if_rsp_data, last_if_data);
      end
      @(posedge clk); #1;
    end
    if_rsp_ready = 1'b0;
    ls_rsp_ready = 1'b0;
    if (own_if) last_if_data = exp_data;
    else last_ls_data = exp_data;
  endtask

  // Start a fetch and pull reset while it sits in CAPTURE; everything must
  // drop to reset values straight away, without waiting for a clock edge.
  task automatic resetDuringFetch(input logic [ADDR_W-1:0] addr);
    if_req_valid = 1'b1;
    if_req_addr  = addr;
    ls_req_valid = 1'b0;
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_pre_busy", busy, 1);
    checkOutput("rst_pre_addr", ram_address, addr);
    #1 rst = 1'b1;
    #1 checkResetState("rst_mid");
    starve_model = 0;
    last_if_data = '0;
    last_ls_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int g, c1, c2;
    int exp_seq [9] = '{2, 2, 1, 2, 2, 1, 2, 2, 1};
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[1023] = 32'h766E2C96;
    ref_mem[1023] = 32'h766E2C96;

    #1 rst = 1'b1;
    #2 checkResetState("reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] fetch from top of memory");
    applyStimulus(1, 10'd1023, 0, 0, 10'd0, 32'h0, 0, 0, g, c1);
    checkOutput("fetch_grant", g, 1);

    $display("[TB] store then load addr 438");
    applyStimulus(0, 10'd0, 1, 1, 10'd438, 32'h0000_01B6, 0, 0, g, c1);
    applyStimulus(0, 10'd0, 1, 0, 10'd438, 32'h0, 0, 0, g, c1);
    checkOutput("load438_data", ls_rsp_data, 32'h0000_01B6);

    $display("[TB] both requesters held valid");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, 10'd0, 1, 0, 10'd5, 32'h0, 0, 0, g, c1);
      checkOutput($sformatf("grant_seq_%0d", k), g, exp_seq[k]);
    end

    $display("[TB] load with response back-pressure");
    applyStimulus(0, 10'd0, 1, 0, 10'd777, 32'h0, 10, 1, g, c1);

    $display("[TB] reset during fetch capture");
    resetDuringFetch(10'd777);
    applyStimulus(1, 10'd0, 0, 0, 10'd0, 32'h0, 0, 0, g, c1);

    $display("[TB] back-to-back stores at both ends");
    applyStimulus(0, 10'd0, 1, 1, 10'd0, 32'hA5A5_0001, 0, 0, g, c1);
    applyStimulus(0, 10'd0, 1, 1, 10'd1023, 32'h5A5A_03FF, 0, 0, g, c2);
    checkOutput("b2b_gap", c2 - c1, 2);
    applyStimulus(0, 10'd0, 1, 0, 10'd0, 32'h0, 1, 0, g, c1);
    applyStimulus(1, 10'd1023, 0, 0, 10'd0, 32'h0, 2, 0, g, c1);

    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      bit iv, lv, we, scr;
      logic [ADDR_W-1:0] ia, la;
      int r;
      iv = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) != 0);
      we = 1'($urandom);
      scr = 1'($urandom);
      r = $urandom_range(0, 7);
      ia = (r == 0) ? 10'd0 : (r == 1) ? 10'd1023 : ADDR_W'($urandom);
      r = $urandom_range(0, 7);
      la = (r == 0) ? 10'd0 : (r == 1) ? 10'd1023 : ADDR_W'($urandom_range(0, 15));
      applyStimulus(iv, ia, lv, we, la, $urandom, $urandom_range(0, 3), scr, g, c1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

- Single-port memory controller that sits between the CORDIC processor core and the `ram` block, acting as the initiator on the RAM interface.
- Arbitrates two requesters: instruction fetch (read-only) and load/store (read/write).
- Sequences each access around the RAM's one-cycle registered read latency and returns read data through valid/ready response channels.

## Interface
Parameters:
- `ADDR_W`, 10, word address width (1024 × 32-bit words)
- `DATA_W`, 32, data word width
- `STARVE_MAX`, 2, consecutive load/store grants allowed while fetch is pending

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `if_req_valid` in 1 / `if_req_ready` out 1 / `if_req_addr` in ADDR_W: fetch request
- `if_rsp_valid` out 1 / `if_rsp_ready` in 1 / `if_rsp_data` out DATA_W: fetch response
- `ls_req_valid` in 1 / `ls_req_ready` out 1: load/store request handshake
- `ls_req_we` in 1: 1 = store, 0 = load
- `ls_req_addr` in ADDR_W / `ls_req_wdata` in DATA_W: load/store request address and store data
- `ls_rsp_valid` out 1 / `ls_rsp_ready` in 1 / `ls_rsp_data` out DATA_W: load response; loads only
- `ram_wr_en` out 1 / `ram_address` out ADDR_W / `ram_data_in` out DATA_W: to RAM
- `ram_data_out` in DATA_W: from RAM, valid the cycle after the address is presented with `ram_wr_en`=0
- `busy` out 1: high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP. Exactly one transaction is in flight at a time.
- IDLE:
  - `if_req_ready` and `ls_req_ready` are driven combinationally from the grant; at most one is high.
  - Grant rule: `ls` has priority over `if`. Exception: if `if_req_valid` is high and `starve_cnt` == `STARVE_MAX`, `if` is granted.
  - `starve_cnt`:
    - increments on each `ls` grant while `if_req_valid` is high;
    - clears on an `if` grant;
    - clears on any `ls` grant with `if_req_valid` low;
    - saturates at `STARVE_MAX`.
- On handshake, the controller latches address, we (forced 0 for `if`), wdata and requester ID into the `ram_*` registers, then moves to ACCESS.
- ACCESS: registered `ram_*` outputs are driven.
  - Store: `ram_wr_en`=1 for this single cycle only; next state IDLE. No response is generated.
  - Load/fetch: `ram_wr_en`=0; next state CAPTURE.
- CAPTURE: `ram_address` is held. `ram_data_out` is copied into the response register of the owning requester; next state RESP.
- RESP: the owner's `*_rsp_valid`=1 and the data is held stable until `*_rsp_ready`. On `valid & ready`, next state is IDLE. No new request is accepted in RESP.
- `*_rsp_data` holds its last value after the handshake.
- Outside ACCESS, `ram_wr_en`=0. `ram_address` and `ram_data_in` hold their last values.
- Addresses are used as-is: no wrap or offset, and the full range 0..2^ADDR_W−1 is legal.

## Timing
- Reset values: all valid/ready outputs 0, `ram_wr_en` 0, `ram_address` 0, `ram_data_in` 0, response data 0, `busy` 0, `starve_cnt` 0, state IDLE.
- Request accepted at edge N:
  - ACCESS occupies cycle N+1;
  - CAPTURE occupies cycle N+2;
  - `rsp_valid` rises in cycle N+3.
- Read latency is 3 cycles from request acceptance to `rsp_valid`. Best-case read throughput is 1 per 4 cycles.
- A store occupies 1 cycle after acceptance. The next request can be accepted in cycle N+2.
- Simultaneous `if`/`ls` valid in IDLE: the grant rule above applies; the loser's ready stays 0.
- Response back-pressure (`rsp_ready`=0) stalls indefinitely in RESP; data stays stable.
- `rst` asserted mid-transaction:
  - immediate return to reset values, including `ram_wr_en`→0 asynchronously;
  - any in-flight transaction is dropped and the requester reissues it;
  - a store caught in ACCESS is not guaranteed to complete.
- Request inputs are sampled only at the handshake edge; changes at other times are ignored.

## Structure
- `mem_pkg`:
  - `ADDR_W`/`DATA_W` defaults;
  - `mem_state_t` enum {IDLE, ACCESS, CAPTURE, RESP};
  - `req_id_t` enum {REQ_IF, REQ_LS}.
- Sub-module `mem_arb`: combinational grant generation plus the `starve_cnt` register; outputs the grant and updates the counter.
- `mem_ctrl` holds the FSM, RAM drive registers and response registers.
- Bench instantiates `mem_ctrl` with the existing `ram` block.

## Test plan
- Preload RAM[1023]=32'h766E2C96; fetch addr 1023 → `if_rsp_valid` in cycle N+3 with data 32'h766E2C96, and `ls_rsp_valid` stays 0.
- Store 32'h0000_01B6 to addr 438, then load addr 438 → `ram_wr_en` high for exactly 1 cycle; load returns 32'h0000_01B6.
- Hold both valids high continuously (`ls` reads addr 5, `if` reads addr 0) → grant order ls, ls, if, ls, ls, if…; no requester is starved.
- Load with `ls_rsp_ready`=0 for 10 cycles → `ls_rsp_valid` and `ls_rsp_data` stay stable; both request readies stay 0 until the handshake.
- Assert `rst` during CAPTURE of a fetch → all outputs return to reset values the same cycle; after release, a fresh fetch of addr 0 completes normally.
- Back-to-back stores to addr 0 and addr 1023 → accepted 2 cycles apart; a later read-back returns the stored values.
